// File: rtl/pipelined_extend_adder.sv
// Wide adder a + ext(b). b is zero- or sign-extended per transaction, and the carry chain is split over STAGES registered chunks.
// Latency: STAGES cycles from accept to out_valid, with one result per cycle when out_ready is held high.
// Backpressure: a single global stall. in_ready = !out_valid | out_ready, and every stage holds while stalled.
//
// Ports: clk/rst (async active-high); in_valid/in_ready with a, b, sign_ext, tag_in;
//        out_valid/out_ready with sum (MSB = carry-out) and tag_out; busy = any stage occupied.
module pipelined_extend_adder #(
    parameter int A_WIDTH   = 63,
    parameter int B_WIDTH   = 41,
    parameter int STAGES    = 3,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 sign_ext,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_WIDTH:0]     sum,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 busy
);
    localparam int CHUNK = (A_WIDTH + STAGES - 1) / STAGES;
    // Ones over b's native width. Its complement selects the bits filled by sign extension.
    // When B_WIDTH == A_WIDTH the complement is all zeros, so extension is a no-op.
    localparam logic [A_WIDTH-1:0] LOW_MASK = {A_WIDTH{1'b1}} >> (A_WIDTH - B_WIDTH);

    logic               advance;
    logic [STAGES-1:0]  vld;
    logic [A_WIDTH-1:0] b_ext;

    assign b_ext     = A_WIDTH'(b) | ({A_WIDTH{sign_ext & b[B_WIDTH-1]}} & ~LOW_MASK);
    assign advance   = ~vld[STAGES-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[STAGES-1];
    assign busy      = |vld;

    // Stage k adds operand bits [LO, HI) and registers the following:
    //   res_q : result bits [0, HI) completed so far (de-skew)
    //   c_q   : the carry out of bit HI-1
    //   g_sk  : operand bits [HI, A_WIDTH) not yet added (skew), right-aligned
    // With a ceil-sized chunk, trailing stages can be empty (W == 0). Such stages only delay the data.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = (k * CHUNK < A_WIDTH) ? k * CHUNK : A_WIDTH;
        localparam int HI = (LO + CHUNK < A_WIDTH) ? LO + CHUNK : A_WIDTH;
        localparam int W  = HI - LO;

        logic                 v_q;
        logic                 c_q;
        logic [TAG_WIDTH-1:0] tag_q;
        logic [HI-1:0]        res_q;
        logic                 v_nxt;
        logic                 c_nxt;
        logic [TAG_WIDTH-1:0] tag_nxt;
        logic [HI-1:0]        res_nxt;

        if (k == 0) begin : g_src
            logic [W:0] part;
            assign part    = {1'b0, a[W-1:0]} + {1'b0, b_ext[W-1:0]};
            assign res_nxt = part[W-1:0];
            assign c_nxt   = part[W];
            assign v_nxt   = in_valid;
            assign tag_nxt = tag_in;
        end else if (W > 0) begin : g_src
            logic [W:0] part;
            assign part    = {1'b0, g_stg[k-1].g_sk.a_q[W-1:0]}
                           + {1'b0, g_stg[k-1].g_sk.b_q[W-1:0]}
                           + {{W{1'b0}}, g_stg[k-1].c_q};
            assign res_nxt = {part[W-1:0], g_stg[k-1].res_q};
            assign c_nxt   = part[W];
            assign v_nxt   = vld[k-1];
            assign tag_nxt = g_stg[k-1].tag_q;
        end else begin : g_src
            assign res_nxt = g_stg[k-1].res_q;
            assign c_nxt   = g_stg[k-1].c_q;
            assign v_nxt   = vld[k-1];
            assign tag_nxt = g_stg[k-1].tag_q;
        end

        if (HI < A_WIDTH) begin : g_sk
            logic [A_WIDTH-HI-1:0] a_q;
            logic [A_WIDTH-HI-1:0] b_q;
            logic [A_WIDTH-HI-1:0] a_nxt;
            logic [A_WIDTH-HI-1:0] b_nxt;

            if (k == 0) begin : g_fwd
                assign a_nxt = a[A_WIDTH-1:HI];
                assign b_nxt = b_ext[A_WIDTH-1:HI];
            end else begin : g_fwd
                assign a_nxt = g_stg[k-1].g_sk.a_q[A_WIDTH-LO-1:W];
                assign b_nxt = g_stg[k-1].g_sk.b_q[A_WIDTH-LO-1:W];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                end
            end
        end

        // Bubbles shift with everything else. Only v_q marks an entry as meaningful.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                tag_q <= '0;
                res_q <= '0;
            end else if (advance) begin
                v_q   <= v_nxt;
                c_q   <= c_nxt;
                tag_q <= tag_nxt;
                res_q <= res_nxt;
            end
        end

        assign vld[k] = v_q;
    end

    assign sum     = {g_stg[STAGES-1].c_q, g_stg[STAGES-1].res_q};
    assign tag_out = g_stg[STAGES-1].tag_q;

endmodule

// File: tb/tb_pipelined_extend_adder.sv
module tb_pipelined_extend_adder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [62:0] a;
    logic [40:0] b;
    logic        sign_ext;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic [3:0]  tag_out;
    logic        busy;

    // Second and third instances only receive transactions that the main instance accepts.
    // Both have out_ready tied high, so their latency is always exact.
    logic        in_valid_x;
    logic        in_ready1, out_valid1, busy1;
    logic [63:0] sum1;
    logic [3:0]  tag1;
    logic        in_ready2, out_valid2, busy2;
    logic [16:0] sum2;
    logic [3:0]  tag2;
    logic        one;

    assign in_valid_x = in_valid & in_ready;
    assign one        = 1'b1;

    pipelined_extend_adder #(.A_WIDTH(63), .B_WIDTH(41), .STAGES(3), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sign_ext(sign_ext), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .tag_out(tag_out), .busy(busy));

    pipelined_extend_adder #(.A_WIDTH(63), .B_WIDTH(41), .STAGES(1), .TAG_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready1), .a(a), .b(b),
        .sign_ext(sign_ext), .tag_in(tag_in), .out_valid(out_valid1), .out_ready(one),
        .sum(sum1), .tag_out(tag1), .busy(busy1));

    pipelined_extend_adder #(.A_WIDTH(16), .B_WIDTH(16), .STAGES(4), .TAG_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready2), .a(a[15:0]), .b(b[15:0]),
        .sign_ext(sign_ext), .tag_in(tag_in), .out_valid(out_valid2), .out_ready(one),
        .sum(sum2), .tag_out(tag2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] s;
        logic [3:0]  t;
        int          c;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    ent_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   pops   = 0;
    bit   lat_chk = 1'b1;

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] m;
        m = '1;
        return (w >= 64) ? m : (m >> (64 - w));
    endfunction

    // The sum is a + ext(b), with both operands taken as aw-bit unsigned values.
    function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y,
                                            input int aw, input int bw, input bit se);
        logic [63:0] am, bm;
        am = x & wmask(aw);
        bm = y & wmask(bw);
        if (se && bw < aw && bm[bw-1]) bm = bm | (wmask(aw) & ~wmask(bw));
        return {1'b0, am} + {1'b0, bm};
    endfunction

    task automatic chk(input string name, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs and check the outputs against the queues.
    // Update the queues from the handshakes, then advance past the next rising edge.
    task automatic cyc(input bit v, input logic [62:0] ia, input logic [40:0] ib,
                       input bit se, input logic [3:0] tg, input bit ordy);
        ent_t e;
        bit   exp_ov;
        in_valid = v; a = ia; b = ib; sign_ext = se; tag_in = tg; out_ready = ordy;
        #1;
        chk("busy", busy, q0.size() != 0);
        if (lat_chk) begin
            exp_ov = (q0.size() != 0) && (cyc_n - q0[0].c == 3);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, !exp_ov || ordy);
        end else if (q0.size() == 0) begin
            chk("out_valid_idle", out_valid, 1'b0);
        end
        if (out_valid && out_ready && q0.size() != 0) begin
            e = q0.pop_front();
            chk("sum", sum, e.s);
            chk("tag_out", tag_out, e.t);
            pops++;
        end
        chk("busy1", busy1, q1.size() != 0);
        chk("out_valid1", out_valid1, (q1.size() != 0) && (cyc_n - q1[0].c == 1));
        if (out_valid1 && q1.size() != 0) begin
            e = q1.pop_front();
            chk("sum1", sum1, e.s);
            chk("tag1", tag1, e.t);
        end
        chk("busy2", busy2, q2.size() != 0);
        chk("out_valid2", out_valid2, (q2.size() != 0) && (cyc_n - q2[0].c == 4));
        if (out_valid2 && q2.size() != 0) begin
            e = q2.pop_front();
            chk("sum2", sum2, e.s);
            chk("tag2", tag2, e.t);
        end
        if (v && in_ready) begin
            e.c = cyc_n;
            e.t = tg;
            e.s = ref_sum({1'b0, ia}, {23'b0, ib}, 63, 41, se);
            q0.push_back(e);
            q1.push_back(e);
            e.s = ref_sum({1'b0, ia}, {23'b0, ib}, 16, 16, se);
            q2.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 4'h0, 1'b1);
    endtask

    logic [63:0] ra, rb;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sign_ext = 1'b0; tag_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_tag", tag_out, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid2", out_valid2, 1'b0);
        rst = 1'b0;

        // Carry ripple through every chunk.
        cyc(1'b1, 63'h7FFF_FFFF_FFFF_FFFF, 41'd1, 1'b0, 4'h3, 1'b1);
        chk("s1_sum_stages1", sum1, 64'h8000_0000_0000_0000);
        idle(2);
        chk("s1_out_valid", out_valid, 1'b1);
        chk("s1_sum", sum, 64'h8000_0000_0000_0000);
        chk("s1_tag", tag_out, 4'h3);
        idle(1);
        chk("s1_sum_w16", sum2, 17'h1_0000);
        idle(2);

        // Sign extension and zero extension of the same operands.
        cyc(1'b1, 63'd5, 41'h1FF_FFFF_FFFF, 1'b1, 4'hA, 1'b1);
        cyc(1'b1, 63'd5, 41'h1FF_FFFF_FFFF, 1'b0, 4'hB, 1'b1);
        idle(1);
        chk("sx_sum", sum, 64'h8000_0000_0000_0004);
        chk("sx_tag", tag_out, 4'hA);
        idle(1);
        chk("zx_sum", sum, 64'h0000_0200_0000_0004);
        chk("zx_tag", tag_out, 4'hB);
        idle(3);

        // Back-to-back stream with simultaneous accept and retire.
        for (int i = 0; i < 8; i++) cyc(1'b1, 63'(i), 41'(i), 1'b0, 4'(i), 1'b1);
        idle(4);

        // Fill the pipe, then stall for 5 cycles.
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            cyc(1'b1, ra[62:0], rb[40:0], 1'b1, 4'(i + 4), 1'b1);
        end
        lat_chk = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ra = {$urandom, $urandom};
            cyc(1'b1, ra[62:0], ra[40:0], 1'b0, 4'hF, 1'b0);
            chk("stall_sum", sum, q0[0].s);
            chk("stall_tag", tag_out, q0[0].t);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        pops = 0;
        idle(3);
        chk("release_pops", pops, 3);
        chk("release_empty", q0.size(), 0);
        lat_chk = 1'b1;
        idle(1);

        // Bubble pattern 1,0,1.
        cyc(1'b1, 63'd100, 41'd7, 1'b0, 4'h1, 1'b1);
        cyc(1'b1 & 1'b0, 63'd0, 41'd0, 1'b0, 4'h0, 1'b1);
        cyc(1'b1, 63'd200, 41'h100_0000_0000, 1'b1, 4'h2, 1'b1);
        idle(5);

        // Reset with three entries in flight.
        for (int i = 0; i < 3; i++) cyc(1'b1, 63'(i + 9), 41'd3, 1'b0, 4'(i), 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_busy2", busy2, 1'b0);
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 63'd1, 41'd2, 1'b0, 4'h5, 1'b1);
        idle(2);
        chk("post_rst_sum", sum, 64'd3);
        chk("post_rst_out_valid", out_valid, 1'b1);
        idle(3);

        // Random traffic with random backpressure.
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = '1;
            cyc(1'($urandom_range(0, 1)), ra[62:0], rb[40:0], 1'($urandom_range(0, 1)),
                4'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(6);
        chk("drain_empty", q0.size(), 0);
        chk("drain_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
